// File: rtl/jtdsp16_pio_fifo_if.sv
// jtdsp16_pio_fifo_if: bundle of the CPU-side and external-bus-side signals of the
// DSP16 parallel I/O port.
//   slave  : the port block (consumes CPU requests, drives the external bus)
//   master : the CPU / environment side
// Signals
//   stlen, wr, wr_ch, wr_data, rd_req, rd_ch, ovf_clr, ien, iack, pbus_in : to port
//   rd_ready, rd_valid, rd_data, full, ovf, irq_out, pbus_out, psel,
//   pods_n, pids_n                                                       : from port
interface jtdsp16_pio_fifo_if #(
  parameter int unsigned DW  = 16,
  parameter int unsigned NCH = 2,
  parameter int unsigned STW = 3,
  parameter int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [STW-1:0] stlen;
  logic           wr;
  logic [CHW-1:0] wr_ch;
  logic [DW-1:0]  wr_data;
  logic           rd_req;
  logic [CHW-1:0] rd_ch;
  logic           rd_ready;
  logic           rd_valid;
  logic [DW-1:0]  rd_data;
  logic           full;
  logic           ovf;
  logic           ovf_clr;
  logic           ien;
  logic           iack;
  logic           irq_out;
  logic [DW-1:0]  pbus_in;
  logic [DW-1:0]  pbus_out;
  logic [NCH-1:0] psel;
  logic           pods_n;
  logic           pids_n;

  modport slave (
    input  stlen, wr, wr_ch, wr_data, rd_req, rd_ch, ovf_clr, ien, iack, pbus_in,
    output rd_ready, rd_valid, rd_data, full, ovf, irq_out, pbus_out, psel, pods_n, pids_n
  );

  modport master (
    output stlen, wr, wr_ch, wr_data, rd_req, rd_ch, ovf_clr, ien, iack, pbus_in,
    input  rd_ready, rd_valid, rd_data, full, ovf, irq_out, pbus_out, psel, pods_n, pids_n
  );
endinterface

// File: rtl/jtdsp16_pio_fifo.sv
// jtdsp16_pio_fifo: DSP16 parallel I/O port in active mode. CPU writes queue in a
// FIFO and drain to the external bus as pods_n strobes; CPU reads wait for the FIFO
// to drain, then run a pids_n strobe and return the sampled bus word.
// Ports
//   rst   : asynchronous reset, active high
//   clk   : clock
//   i_cen : clock enable, all state advances only when high
//   pio   : slave side of jtdsp16_pio_fifo_if (CPU requests, status, external bus)
// Optional feature (macro JTDSP16_PIO_EXTIRQ_EN)
//   i_ext_irq    : external interrupt, rising edge sets irq_out when ien=1
//   o_ext_irq_st : synchronised ext_irq level
module jtdsp16_pio_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NCH   = 2,
  parameter int unsigned STW   = 3
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              i_cen,
`ifdef JTDSP16_PIO_EXTIRQ_EN
  input  logic              i_ext_irq,
  output logic              o_ext_irq_st,
`endif
  jtdsp16_pio_fifo_if.slave pio
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StSetup, StOstb, StIstb} st_e;

  st_e            r_st, w_st_nxt;
  logic [AW:0]    r_wptr, r_rptr, w_count;
  logic [CHW-1:0] r_ch_mem  [DEPTH];
  logic [DW-1:0]  r_dat_mem [DEPTH];
  logic           w_empty, w_full, w_push, w_pop, w_ovf_set, w_empty_evt;
  logic           w_rd_ready, w_iack_fall, w_ext_rise, w_irq_set;
  logic           r_ovf, r_irq, r_iack_q;

  // Strobe datapath registers and their next values
  logic           r_is_rd, w_is_rd_nxt;
  logic [STW-1:0] r_cnt, w_cnt_nxt;
  logic [NCH-1:0] r_psel, w_psel_nxt;
  logic [DW-1:0]  r_pbus, w_pbus_nxt;
  logic           r_pods_n, w_pods_n_nxt, r_pids_n, w_pids_n_nxt;
  logic           r_rd_pend, w_rd_pend_nxt;
  logic [CHW-1:0] r_rd_ch, w_rd_ch_nxt;
  logic [DW-1:0]  r_rd_data, w_rd_data_nxt;
  logic           r_rd_valid, w_rd_valid_nxt;

  // FIFO bookkeeping: pointers carry one extra wrap bit so full/empty are distinct
  assign w_count    = r_wptr - r_rptr;
  assign w_empty    = (w_count == '0);
  assign w_full     = (w_count == FullCnt);
  assign w_pop      = i_cen && (r_st == StIdle) && !w_empty;
  // A pop in the same tick frees the slot, so a push is accepted even when full
  assign w_push     = i_cen && pio.wr && (!w_full || w_pop);
  assign w_ovf_set  = i_cen && pio.wr && w_full && !w_pop;
  assign w_empty_evt = w_pop && !w_push && (w_count == (AW+1)'(1));
  assign w_rd_ready = (r_st == StIdle) && w_empty && !r_rd_pend;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ch_mem[r_wptr[AW-1:0]]  <= pio.wr_ch;
      r_dat_mem[r_wptr[AW-1:0]] <= pio.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st <= StIdle;
    end else if (i_cen) begin
      r_st <= w_st_nxt;
    end
  end

  always_comb begin
    w_st_nxt       = r_st;
    w_is_rd_nxt    = r_is_rd;
    w_cnt_nxt      = r_cnt;
    w_psel_nxt     = r_psel;
    w_pbus_nxt     = r_pbus;
    w_pods_n_nxt   = r_pods_n;
    w_pids_n_nxt   = r_pids_n;
    w_rd_pend_nxt  = r_rd_pend;
    w_rd_ch_nxt    = r_rd_ch;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    if (pio.rd_req && w_rd_ready) begin
      w_rd_pend_nxt = 1'b1;
      w_rd_ch_nxt   = pio.rd_ch;
    end
    unique case (r_st)
      StIdle: begin
        // Queued writes go first so a read always observes earlier writes
        if (!w_empty) begin
          w_st_nxt    = StSetup;
          w_is_rd_nxt = 1'b0;
          w_psel_nxt  = NCH'(1) << r_ch_mem[r_rptr[AW-1:0]];
          w_pbus_nxt  = r_dat_mem[r_rptr[AW-1:0]];
        end else if (r_rd_pend) begin
          w_st_nxt    = StSetup;
          w_is_rd_nxt = 1'b1;
          w_psel_nxt  = NCH'(1) << r_rd_ch;
        end
      end
      StSetup: begin
        w_st_nxt     = r_is_rd ? StIstb : StOstb;
        w_cnt_nxt    = pio.stlen;
        w_pods_n_nxt = r_is_rd;
        w_pids_n_nxt = !r_is_rd;
      end
      StOstb, StIstb: begin
        if (r_cnt == '0) begin
          w_st_nxt     = StIdle;
          w_pods_n_nxt = 1'b1;
          w_pids_n_nxt = 1'b1;
          w_psel_nxt   = '0;
          if (r_st == StIstb) begin
            w_rd_data_nxt  = pio.pbus_in;
            w_rd_valid_nxt = 1'b1;
            w_rd_pend_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_st_nxt = StIdle;
    endcase
  end

  assign w_iack_fall = r_iack_q && !pio.iack;
  assign w_irq_set   = pio.ien && (w_empty_evt || w_ext_rise);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_is_rd    <= 1'b0;
      r_cnt      <= '0;
      r_psel     <= '0;
      r_pbus     <= '0;
      r_pods_n   <= 1'b1;
      r_pids_n   <= 1'b1;
      r_rd_pend  <= 1'b0;
      r_rd_ch    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_irq      <= 1'b0;
      r_iack_q   <= 1'b0;
    end else if (i_cen) begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_is_rd    <= w_is_rd_nxt;
      r_cnt      <= w_cnt_nxt;
      r_psel     <= w_psel_nxt;
      r_pbus     <= w_pbus_nxt;
      r_pods_n   <= w_pods_n_nxt;
      r_pids_n   <= w_pids_n_nxt;
      r_rd_pend  <= w_rd_pend_nxt;
      r_rd_ch    <= w_rd_ch_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      // Set wins over clear for both sticky flags
      r_ovf      <= w_ovf_set || (r_ovf && !pio.ovf_clr);
      r_irq      <= w_irq_set || (r_irq && !w_iack_fall);
      r_iack_q   <= pio.iack;
    end
  end

`ifdef JTDSP16_PIO_EXTIRQ_EN
  logic r_ext_s1, r_ext_s2, r_ext_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext_s1 <= 1'b0;
      r_ext_s2 <= 1'b0;
      r_ext_s3 <= 1'b0;
    end else if (i_cen) begin
      r_ext_s1 <= i_ext_irq;
      r_ext_s2 <= r_ext_s1;
      r_ext_s3 <= r_ext_s2;
    end
  end

  assign w_ext_rise   = r_ext_s2 && !r_ext_s3;
  assign o_ext_irq_st = r_ext_s2;
`else
  assign w_ext_rise = 1'b0;
`endif

  assign pio.rd_ready = w_rd_ready;
  assign pio.rd_valid = r_rd_valid;
  assign pio.rd_data  = r_rd_data;
  assign pio.full     = w_full;
  assign pio.ovf      = r_ovf;
  assign pio.irq_out  = r_irq;
  assign pio.pbus_out = r_pbus;
  assign pio.psel     = r_psel;
  assign pio.pods_n   = r_pods_n;
  assign pio.pids_n   = r_pids_n;
endmodule

// File: tb/tb_jtdsp16_pio_fifo.sv
`timescale 1ns/1ps
module tb_jtdsp16_pio_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b1;
`ifdef JTDSP16_PIO_EXTIRQ_EN
  logic ext_irq = 1'b0;
  logic ext_irq_st;
`endif

  int n_pass  = 0;
  int n_total = 0;

  jtdsp16_pio_fifo_if #(.DW(16), .NCH(2), .STW(3)) pio ();

  jtdsp16_pio_fifo #(.DW(16), .DEPTH(4), .NCH(2), .STW(3)) dut (
    .rst          (rst),
    .clk          (clk),
    .i_cen        (cen),
`ifdef JTDSP16_PIO_EXTIRQ_EN
    .i_ext_irq    (ext_irq),
    .o_ext_irq_st (ext_irq_st),
`endif
    .pio          (pio)
  );

  always #5 clk = ~clk;

  // Bus monitor: records every strobe (word, select, start time, length in ticks)
  logic [15:0] w_data[$];
  logic [1:0]  w_sel[$];
  time         w_time[$];
  int          w_len[$];
  logic [1:0]  r_sel[$];
  time         r_time[$];
  int          r_len[$];
  int          rv_cnt = 0;
  int          cnt_o = 0, cnt_i = 0;
  logic        prev_pods = 1'b1, prev_pids = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_pods && !pio.pods_n) begin
        w_data.push_back(pio.pbus_out);
        w_sel.push_back(pio.psel);
        w_time.push_back($time);
        cnt_o = 0;
      end
      if (!pio.pods_n) cnt_o++;
      if (!prev_pods && pio.pods_n) w_len.push_back(cnt_o);
      if (prev_pids && !pio.pids_n) begin
        r_sel.push_back(pio.psel);
        r_time.push_back($time);
        cnt_i = 0;
      end
      if (!pio.pids_n) cnt_i++;
      if (!prev_pids && pio.pids_n) r_len.push_back(cnt_i);
      if (pio.rd_valid) rv_cnt++;
    end
    prev_pods = pio.pods_n;
    prev_pids = pio.pids_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ch, input logic [15:0] d);
    pio.wr      = 1'b1;
    pio.wr_ch   = ch;
    pio.wr_data = d;
    tick();
    pio.wr      = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (pio.rd_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (pio.rd_ready !== 1'b1) begin
      n_total++;
      $display("FAIL %s_timeout: rd_ready=%b want 1 within 300 ticks", nm, pio.rd_ready);
    end
  endtask

  task automatic test_reset();
    pio.stlen = 3'd1; pio.wr = 0; pio.wr_ch = 0; pio.wr_data = 0; pio.rd_req = 0;
    pio.rd_ch = 0; pio.ovf_clr = 0; pio.ien = 0; pio.iack = 0; pio.pbus_in = 16'h5A5A;
    rst = 1'b1;
    repeat (3) tick();
    n_total++; if (pio.pods_n !== 1'b1) $display("FAIL rst_pods_n: got %b want 1", pio.pods_n); else n_pass++;
    n_total++; if (pio.pids_n !== 1'b1) $display("FAIL rst_pids_n: got %b want 1", pio.pids_n); else n_pass++;
    n_total++; if (pio.psel !== 2'b00) $display("FAIL rst_psel: got %b want 00", pio.psel); else n_pass++;
    n_total++; if (pio.pbus_out !== 16'h0) $display("FAIL rst_pbus_out: got %h want 0000", pio.pbus_out); else n_pass++;
    n_total++; if (pio.rd_data !== 16'h0) $display("FAIL rst_rd_data: got %h want 0000", pio.rd_data); else n_pass++;
    n_total++; if (pio.rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %b want 0", pio.rd_valid); else n_pass++;
    n_total++; if (pio.full !== 1'b0) $display("FAIL rst_full: got %b want 0", pio.full); else n_pass++;
    n_total++; if (pio.ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", pio.ovf); else n_pass++;
    n_total++; if (pio.irq_out !== 1'b0) $display("FAIL rst_irq: got %b want 0", pio.irq_out); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_total++; if (pio.rd_ready !== 1'b1) $display("FAIL rst_rd_ready: got %b want 1", pio.rd_ready); else n_pass++;
  endtask

  task automatic test_single_write();
    int base = w_data.size();
    int l;
    pio.stlen = 3'd1;
    pio.ien   = 1'b1;
    push(1'b1, 16'h1234);
    tick();
    n_total++; if (pio.psel !== 2'b10) $display("FAIL sw_setup_psel: got %b want 10", pio.psel); else n_pass++;
    n_total++; if (pio.pbus_out !== 16'h1234) $display("FAIL sw_setup_pbus: got %h want 1234", pio.pbus_out); else n_pass++;
    n_total++; if (pio.pods_n !== 1'b1) $display("FAIL sw_setup_pods_n: got %b want 1", pio.pods_n); else n_pass++;
    n_total++; if (pio.irq_out !== 1'b1) $display("FAIL sw_irq_set: got %b want 1", pio.irq_out); else n_pass++;
    tick();
    n_total++; if (pio.pods_n !== 1'b0) $display("FAIL sw_strobe1: got %b want 0", pio.pods_n); else n_pass++;
    tick();
    n_total++; if (pio.pods_n !== 1'b0) $display("FAIL sw_strobe2: got %b want 0", pio.pods_n); else n_pass++;
    tick();
    n_total++; if (pio.pods_n !== 1'b1) $display("FAIL sw_strobe_end: got %b want 1", pio.pods_n); else n_pass++;
    n_total++; if (pio.psel !== 2'b00) $display("FAIL sw_idle_psel: got %b want 00", pio.psel); else n_pass++;
    n_total++; if (pio.pbus_out !== 16'h1234) $display("FAIL sw_pbus_hold: got %h want 1234", pio.pbus_out); else n_pass++;
    tick();
    l = (w_len.size() > base) ? w_len[base] : -1;
    n_total++; if (l != 2) $display("FAIL sw_strobe_len: got %0d want 2", l); else n_pass++;
    pio.iack = 1'b1;
    tick();
    n_total++; if (pio.irq_out !== 1'b1) $display("FAIL sw_irq_hold_iack_hi: got %b want 1", pio.irq_out); else n_pass++;
    pio.iack = 1'b0;
    tick();
    n_total++; if (pio.irq_out !== 1'b0) $display("FAIL sw_irq_clr: got %b want 0", pio.irq_out); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [15:0] exp_d [6];
    logic [1:0]  exp_s [6];
    int base = w_data.size();
    int n = 0;
    exp_d = '{16'h1000, 16'hA001, 16'hB002, 16'hC003, 16'hD004, 16'hF006};
    exp_s = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    pio.ien   = 1'b0;
    pio.stlen = 3'd7;
    push(1'b0, 16'h1000);
    tick();
    push(1'b1, 16'hA001);
    push(1'b0, 16'hB002);
    push(1'b1, 16'hC003);
    push(1'b0, 16'hD004);
    n_total++; if (pio.full !== 1'b1) $display("FAIL ovf_full_at4: got %b want 1", pio.full); else n_pass++;
    n_total++; if (pio.ovf !== 1'b0) $display("FAIL ovf_clear_at4: got %b want 0", pio.ovf); else n_pass++;
    push(1'b1, 16'hE005);
    n_total++; if (pio.ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", pio.ovf); else n_pass++;
    n_total++; if (pio.full !== 1'b1) $display("FAIL ovf_full_after_drop: got %b want 1", pio.full); else n_pass++;
    pio.ovf_clr = 1'b1;
    push(1'b1, 16'hE005);
    n_total++; if (pio.ovf !== 1'b1) $display("FAIL ovf_set_wins_clr: got %b want 1", pio.ovf); else n_pass++;
    tick();
    pio.ovf_clr = 1'b0;
    n_total++; if (pio.ovf !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", pio.ovf); else n_pass++;
    while (pio.pods_n !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    push(1'b1, 16'hF006);
    n_total++; if (pio.full !== 1'b1) $display("FAIL ovf_push_pop_full: got %b want 1", pio.full); else n_pass++;
    n_total++; if (pio.ovf !== 1'b0) $display("FAIL ovf_push_pop_no_ovf: got %b want 0", pio.ovf); else n_pass++;
    wait_idle("ovf_drain");
    repeat (2) tick();
    n_total++;
    if (w_data.size() - base != 6) $display("FAIL ovf_word_count: got %0d want 6", w_data.size() - base);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      logic [15:0] d = (w_data.size() > base + i) ? w_data[base + i] : 16'hxxxx;
      logic [1:0]  s = (w_sel.size() > base + i) ? w_sel[base + i] : 2'bxx;
      n_total++;
      if (d !== exp_d[i] || s !== exp_s[i])
        $display("FAIL ovf_word%0d: got %h/%b want %h/%b", i, d, s, exp_d[i], exp_s[i]);
      else n_pass++;
    end
  endtask

  task automatic test_read_order();
    int bw = w_data.size();
    int br = r_len.size();
    int rv0 = rv_cnt;
    pio.stlen   = 3'd2;
    pio.pbus_in = 16'hC3C3;
    n_total++; if (pio.rd_ready !== 1'b1) $display("FAIL rd_ready_idle: got %b want 1", pio.rd_ready); else n_pass++;
    pio.rd_req = 1'b1;
    pio.rd_ch  = 1'b1;
    push(1'b0, 16'hAAAA);
    repeat (3) tick();
    n_total++; if (pio.rd_ready !== 1'b0) $display("FAIL rd_ready_busy: got %b want 0", pio.rd_ready); else n_pass++;
    pio.rd_req = 1'b0;
    wait_idle("rd_done");
    n_total++; if (pio.rd_valid !== 1'b1) $display("FAIL rd_valid_pulse: got %b want 1", pio.rd_valid); else n_pass++;
    n_total++; if (pio.rd_data !== 16'hC3C3) $display("FAIL rd_data: got %h want c3c3", pio.rd_data); else n_pass++;
    pio.pbus_in = 16'h0000;
    repeat (2) tick();
    n_total++; if (pio.rd_data !== 16'hC3C3) $display("FAIL rd_data_hold: got %h want c3c3", pio.rd_data); else n_pass++;
    n_total++; if (rv_cnt - rv0 != 1) $display("FAIL rd_valid_count: got %0d want 1", rv_cnt - rv0); else n_pass++;
    n_total++;
    if (w_data.size() <= bw || w_data[bw] !== 16'hAAAA)
      $display("FAIL rd_prior_write: got %0d words want 1 word aaaa", w_data.size() - bw);
    else n_pass++;
    n_total++;
    if (r_len.size() <= br || r_len[br] != 3 || r_sel[br] !== 2'b10)
      $display("FAIL rd_strobe: got %0d strobes want one of 3 ticks on psel 10", r_len.size() - br);
    else n_pass++;
    n_total++;
    if (w_time.size() <= bw || r_time.size() <= br || !(w_time[bw] < r_time[br]))
      $display("FAIL rd_order: got write/read strobe order wrong want write first");
    else n_pass++;
  endtask

  task automatic test_stlen_change();
    int base = w_len.size();
    int n = 0;
    int l0, l1;
    pio.stlen = 3'd0;
    push(1'b0, 16'h1111);
    while (pio.pods_n !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    pio.stlen = 3'd3;
    push(1'b1, 16'h2222);
    wait_idle("stlen_drain");
    repeat (2) tick();
    l0 = (w_len.size() > base) ? w_len[base] : -1;
    l1 = (w_len.size() > base + 1) ? w_len[base + 1] : -1;
    n_total++; if (l0 != 1) $display("FAIL stlen_cur_len: got %0d want 1", l0); else n_pass++;
    n_total++; if (l1 != 4) $display("FAIL stlen_next_len: got %0d want 4", l1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int  base = w_time.size();
    time dt;
    pio.stlen = 3'd1;
    pio.ien   = 1'b1;
    push(1'b0, 16'h0B01);
    push(1'b1, 16'h0B02);
    wait_idle("b2b_drain");
    repeat (2) tick();
    dt = (w_time.size() > base + 1) ? w_time[base + 1] - w_time[base] : 0;
    n_total++; if (dt != 40) $display("FAIL b2b_period: got %0t want 40", dt); else n_pass++;
    n_total++;
    if (w_data.size() <= base + 1 || w_data[base + 1] !== 16'h0B02 || w_sel[base + 1] !== 2'b10)
      $display("FAIL b2b_second_word: got %0d words want 0b02 on psel 10", w_data.size() - base);
    else n_pass++;
    n_total++; if (pio.irq_out !== 1'b1) $display("FAIL b2b_irq: got %b want 1", pio.irq_out); else n_pass++;
  endtask

  task automatic test_reset_mid_strobe();
    pio.stlen = 3'd7;
    push(1'b0, 16'h3001);
    push(1'b1, 16'h3002);
    push(1'b0, 16'h3003);
    push(1'b1, 16'h3004);
    push(1'b0, 16'h3005);
    n_total++; if (pio.full !== 1'b1) $display("FAIL rm_full_before: got %b want 1", pio.full); else n_pass++;
    n_total++; if (pio.pods_n !== 1'b0) $display("FAIL rm_strobe_before: got %b want 0", pio.pods_n); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (pio.pods_n !== 1'b1) $display("FAIL rm_pods_n: got %b want 1", pio.pods_n); else n_pass++;
    n_total++; if (pio.psel !== 2'b00) $display("FAIL rm_psel: got %b want 00", pio.psel); else n_pass++;
    n_total++; if (pio.full !== 1'b0) $display("FAIL rm_full: got %b want 0", pio.full); else n_pass++;
    n_total++; if (pio.irq_out !== 1'b0) $display("FAIL rm_irq: got %b want 0", pio.irq_out); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    n_total++; if (pio.pods_n !== 1'b1) $display("FAIL rm_queue_discarded: got %b want 1", pio.pods_n); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_read_order();
    test_stlen_change();
    test_back_to_back();
    test_reset_mid_strobe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
